// File: rtl/trigger_sequencer.sv
// Multi-stage trigger engine: STAGES programmable mask/type/level stages, each with an occurrence count.
// Latency: triggered/done/trigger_pos are registered, valid one cycle after the completing sample is accepted.
// Backpressure: none; every sample_valid cycle is consumed, and sample_valid=0 cycles only act on arm/abort.
module trigger_sequencer #(
  parameter int SIZE    = 32,
  parameter int STAGES  = 8,
  parameter int CNT_W   = 16,
  parameter int SADDR_W = 24,
  localparam int NS_W   = $clog2(STAGES + 1),
  localparam int CS_W   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [SIZE-1:0]           i_sample,
  input  logic                      i_sample_valid,
  input  logic                      i_arm,
  input  logic                      i_abort,
  input  logic [NS_W-1:0]           i_num_stages,
  input  logic [STAGES*SIZE-1:0]    i_stage_mask,
  input  logic [STAGES*SIZE-1:0]    i_stage_type,
  input  logic [STAGES*SIZE-1:0]    i_stage_level,
  input  logic [STAGES*CNT_W-1:0]   i_stage_count,
  output logic                      o_armed,
  output logic                      o_triggered,
  output logic                      o_done,
  output logic [CS_W-1:0]           o_cur_stage,
  output logic [SADDR_W-1:0]        o_trigger_pos
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CS_W-1:0]      r_cur_stage;
  logic [CNT_W-1:0]     r_cnt;
  logic [SADDR_W-1:0]   r_idx;
  logic [SADDR_W-1:0]   r_trigger_pos;
  logic [SIZE-1:0]      r_prev;
  logic                 r_prev_vld;
  logic                 r_triggered;

  logic [NS_W-1:0]      w_eff;
  logic [SIZE-1:0]      w_mask;
  logic [SIZE-1:0]      w_type;
  logic [SIZE-1:0]      w_level;
  logic [CNT_W-1:0]     w_cnt_cfg;
  logic [CNT_W-1:0]     w_need;
  logic [SIZE-1:0]      w_bit_ok;
  logic                 w_match;
  logic                 w_reached;
  logic                 w_last;
  logic                 w_arm_go;
  logic                 w_accept;
  logic                 w_complete;

  // Clamp the programmed stage count to the number of stages actually built.
  always_comb begin
    if (32'(i_num_stages) > STAGES) w_eff = NS_W'(STAGES);
    else                            w_eff = i_num_stages;
  end

  // Select the configuration slice belonging to the active stage.
  always_comb begin
    w_mask    = '0;
    w_type    = '0;
    w_level   = '0;
    w_cnt_cfg = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (32'(r_cur_stage) == k) begin
        w_mask    = i_stage_mask [k*SIZE  +: SIZE];
        w_type    = i_stage_type [k*SIZE  +: SIZE];
        w_level   = i_stage_level[k*SIZE  +: SIZE];
        w_cnt_cfg = i_stage_count[k*CNT_W +: CNT_W];
      end
    end
  end

  // Per-bit match: unmasked bits always pass; edge bits also need a valid, differing previous sample.
  always_comb begin
    w_bit_ok = ~w_mask
             | (~w_type & ~(i_sample ^ w_level))
             | ( w_type & ~(i_sample ^ w_level) & (r_prev ^ i_sample) & {SIZE{r_prev_vld}});
    w_match   = &w_bit_ok;
    w_need    = (w_cnt_cfg == '0) ? CNT_W'(1) : w_cnt_cfg;
    w_reached = ({1'b0, r_cnt} + (CNT_W+1)'(1)) >= {1'b0, w_need};
    w_last    = (32'(r_cur_stage) + 32'd1) == 32'(w_eff);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic; abort takes priority over everything, arm is ignored while armed.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_go    = 1'b0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_arm) begin
            w_state_nxt = ST_ARMED;
            w_arm_go    = 1'b1;
          end
        end
        ST_ARMED: begin
          if (i_sample_valid) begin
            w_accept = 1'b1;
            if ((w_eff == '0) || (w_match && w_reached && w_last)) begin
              w_complete  = 1'b1;
              w_state_nxt = ST_TRIG;
            end
          end
        end
        ST_TRIG: begin
          if (i_arm) begin
            w_state_nxt = ST_ARMED;
            w_arm_go    = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sequence datapath: stage pointer, occurrence count, sample index, previous sample, trigger position.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cur_stage   <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_trigger_pos <= '0;
      r_prev        <= '0;
      r_prev_vld    <= 1'b0;
      r_triggered   <= 1'b0;
    end else begin
      r_triggered <= w_complete;
      if (w_arm_go) begin
        r_cur_stage <= '0;
        r_cnt       <= '0;
        r_idx       <= '0;
        r_prev_vld  <= 1'b0;
      end else if (w_accept) begin
        r_prev     <= i_sample;
        r_prev_vld <= 1'b1;
        if (r_idx != '1) r_idx <= r_idx + SADDR_W'(1);
        if (w_complete) begin
          r_trigger_pos <= r_idx;
          r_cnt         <= '0;
        end else if (w_match) begin
          if (w_reached) begin
            r_cnt       <= '0;
            r_cur_stage <= r_cur_stage + CS_W'(1);
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign o_armed       = (r_state == ST_ARMED);
  assign o_done        = (r_state == ST_TRIG);
  assign o_triggered   = r_triggered;
  assign o_cur_stage   = r_cur_stage;
  assign o_trigger_pos = r_trigger_pos;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios with literal expectations, then randomized traffic.
// Every cycle the DUT outputs are compared with a sequence-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_trigger_sequencer;
  localparam int SIZE = 32, STAGES = 8, CNT_W = 16, SADDR_W = 24;
  localparam int NS_W = $clog2(STAGES + 1);
  localparam int CS_W = $clog2(STAGES);

  logic clk = 1'b0;
  logic reset_n, sample_valid, arm, abort;
  logic [SIZE-1:0] sample;
  logic [NS_W-1:0] num_stages;
  logic [STAGES*SIZE-1:0] stage_mask, stage_type, stage_level;
  logic [STAGES*CNT_W-1:0] stage_count;
  logic armed, triggered, done;
  logic [CS_W-1:0] cur_stage;
  logic [SADDR_W-1:0] trigger_pos;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 idle, 1 armed, 2 triggered.
  int       m_state = 0, m_stage = 0, m_cnt = 0, m_idx = 0, m_pos = 0;
  bit       m_trig = 0, m_pv = 0;
  logic [SIZE-1:0] m_prev = '0;

  trigger_sequencer #(.SIZE(SIZE), .STAGES(STAGES), .CNT_W(CNT_W), .SADDR_W(SADDR_W)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_sample(sample), .i_sample_valid(sample_valid),
    .i_arm(arm), .i_abort(abort), .i_num_stages(num_stages),
    .i_stage_mask(stage_mask), .i_stage_type(stage_type), .i_stage_level(stage_level),
    .i_stage_count(stage_count),
    .o_armed(armed), .o_triggered(triggered), .o_done(done),
    .o_cur_stage(cur_stage), .o_trigger_pos(trigger_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Does the sample satisfy stage k given the previous sample?
  function automatic bit stage_hit(input int k, input logic [SIZE-1:0] s);
    logic [SIZE-1:0] mk, ty, lv;
    mk = stage_mask[k*SIZE +: SIZE];
    ty = stage_type[k*SIZE +: SIZE];
    lv = stage_level[k*SIZE +: SIZE];
    for (int i = 0; i < SIZE; i++) begin
      if (mk[i]) begin
        if (s[i] != lv[i]) return 0;
        if (ty[i] && !(m_pv && m_prev[i] != s[i])) return 0;
      end
    end
    return 1;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int eff, need;
    bit fin;
    m_trig = 0;
    if (!reset_n) begin
      m_state = 0; m_stage = 0; m_cnt = 0; m_idx = 0; m_pos = 0; m_pv = 0; m_prev = '0;
    end else if (abort) begin
      m_state = 0;
    end else if (arm && m_state != 1) begin
      m_state = 1; m_stage = 0; m_cnt = 0; m_idx = 0; m_pv = 0;
    end else if (m_state == 1 && sample_valid) begin
      eff = (int'(num_stages) > STAGES) ? STAGES : int'(num_stages);
      fin = 0;
      if (eff == 0) fin = 1;
      else if (stage_hit(m_stage, sample)) begin
        need = int'(stage_count[m_stage*CNT_W +: CNT_W]);
        if (need == 0) need = 1;
        if (m_cnt + 1 >= need) begin
          m_cnt = 0;
          if (m_stage == eff - 1) fin = 1; else m_stage++;
        end else m_cnt++;
      end
      if (fin) begin m_state = 2; m_trig = 1; m_pos = m_idx; end
      if (m_idx < (1 << SADDR_W) - 1) m_idx++;
      m_prev = sample; m_pv = 1;
    end
  endtask

  task automatic compare();
    chk("armed",       64'(armed),       64'(m_state == 1));
    chk("done",        64'(done),        64'(m_state == 2));
    chk("triggered",   64'(triggered),   64'(m_trig));
    chk("cur_stage",   64'(cur_stage),   64'(m_stage));
    chk("trigger_pos", 64'(trigger_pos), 64'(m_pos));
  endtask

  task automatic cycle(input bit rst, input bit a, input bit ab, input bit v, input logic [SIZE-1:0] s);
    @(negedge clk);
    reset_n = ~rst; arm = a; abort = ab; sample_valid = v; sample = s;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_cfg();
    stage_mask = '0; stage_type = '0; stage_level = '0; stage_count = '0; num_stages = '0;
  endtask

  task automatic cfg_seq2();
    clear_cfg();
    num_stages = NS_W'(2);
    stage_mask[0] = 1'b1; stage_type[0] = 1'b1; stage_level[0] = 1'b1;
    stage_count[0 +: CNT_W] = CNT_W'(3);
    stage_mask[SIZE+4] = 1'b1; stage_level[SIZE+4] = 1'b1;
    stage_count[CNT_W +: CNT_W] = CNT_W'(1);
  endtask

  initial begin
    reset_n = 1'b0; arm = 0; abort = 0; sample_valid = 0; sample = '0;
    clear_cfg();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_armed", 64'(armed), 0);
    chk("reset_pos",   64'(trigger_pos), 0);

    // Single level stage on bit0.
    num_stages = NS_W'(1);
    stage_mask[0] = 1'b1; stage_level[0] = 1'b1; stage_count[0 +: CNT_W] = CNT_W'(1);
    cycle(0, 1, 0, 0, 0);
    chk("t1_armed", 64'(armed), 1);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h1);
    chk("t1_trig", 64'(triggered), 1);
    chk("t1_pos",  64'(trigger_pos), 2);
    chk("t1_done", 64'(done), 1);
    cycle(0, 0, 0, 0, 0);
    chk("t1_pulse_width", 64'(triggered), 0);
    chk("t1_done_hold",   64'(done), 1);

    // Two stages: three rising edges on bit0, then bit4 high.
    cfg_seq2();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, (i % 2 == 1) ? 32'h1 : 32'h0);
    chk("t2_stage1", 64'(cur_stage), 1);
    cycle(0, 0, 0, 1, 32'h10);
    chk("t2_trig", 64'(triggered), 1);
    chk("t2_pos",  64'(trigger_pos), 6);

    // Edge stage: first sample only primes prev.
    clear_cfg();
    num_stages = NS_W'(1);
    stage_mask[0] = 1'b1; stage_type[0] = 1'b1; stage_level[0] = 1'b1;
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h1);
    chk("t3_no_prime_match", 64'(done), 0);
    cycle(0, 0, 0, 1, 32'h1);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h1);
    chk("t3_pos", 64'(trigger_pos), 3);

    // Abort beats arm while armed.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'h0);
    chk("t4_armed", 64'(armed), 0);
    chk("t4_trig",  64'(triggered), 0);

    // Reset mid-sequence at stage 1.
    cfg_seq2();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, (i % 2 == 1) ? 32'h1 : 32'h0);
    cycle(1, 0, 0, 1, 32'h10);
    chk("t5_stage", 64'(cur_stage), 0);
    chk("t5_armed", 64'(armed), 0);
    chk("t5_trig",  64'(triggered), 0);
    cycle(0, 1, 0, 0, 0);
    chk("t5_rearm", 64'(armed), 1);

    // Zero stages: first valid sample after a gap triggers at index 0.
    clear_cfg();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 32'h5);
    chk("t6_still_armed", 64'(armed), 1);
    cycle(0, 0, 0, 1, 32'h7);
    chk("t6_trig", 64'(triggered), 1);
    chk("t6_pos",  64'(trigger_pos), 0);

    // Randomized traffic; configuration only changes while not armed.
    for (int n = 0; n < 4000; n++) begin
      bit r, a, ab, v;
      if (m_state != 1 && $urandom_range(0, 3) == 0) begin
        num_stages = NS_W'($urandom_range(0, 9));
        for (int k = 0; k < STAGES; k++) begin
          stage_mask[k*SIZE +: SIZE]  = ($urandom_range(0, 3) == 0) ? '0 : SIZE'($urandom & 32'hF);
          stage_type[k*SIZE +: SIZE]  = SIZE'($urandom & 32'hF);
          stage_level[k*SIZE +: SIZE] = SIZE'($urandom);
          stage_count[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
        end
      end
      r  = ($urandom_range(0, 299) == 0);
      a  = ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 9) < 7);
      cycle(r, a, ab, v, SIZE'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
